// File: rtl/calc_pkg.sv
// Shared calculator definitions: button channel state and default button count.
package calc_pkg;

    localparam int unsigned CALC_N_BTN = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_REPEAT
    } btn_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop sync, debounce, press/release pulses.
// Auto-repeat is compiled in only when BTN_CONDITIONER_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned REPEAT_CYCLES   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
        $error("btn_debounce_ch: cycle parameters must be >= 1");
    end

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          accept, rise, fall, repeat_fire;
    logic          press_nxt, release_nxt;
    btn_state_t    state, state_nxt;

    assign accept = (s2 != btn_level) && (cnt == CNT_LAST);
    assign rise   = accept & s2;
    assign fall   = accept & ~s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            if (s2 == btn_level) begin
                cnt <= '0;
            end else if (accept) begin
                btn_level <= s2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
        end
    end

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;
    localparam int unsigned RW = $clog2(REPEAT_CYCLES) + 1;

    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic          hold_done, rep_done;

    assign hold_done = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign rep_done  = (rep_cnt == RW'(REPEAT_CYCLES - 1));

    // Counters idle at zero outside their state, so entry always starts a fresh interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            rep_cnt  <= '0;
        end else begin
            case (state)
                ST_HELD: begin
                    hold_cnt <= hold_done ? '0 : hold_cnt + HW'(1);
                    rep_cnt  <= '0;
                end
                ST_REPEAT: begin
                    hold_cnt <= '0;
                    rep_cnt  <= rep_done ? '0 : rep_cnt + RW'(1);
                end
                default: begin
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                end
            endcase
        end
    end

    assign repeat_fire = !fall && (((state == ST_HELD) && hold_done) ||
                                   ((state == ST_REPEAT) && rep_done));
`else
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (rise) state_nxt = ST_HELD;
            ST_HELD: begin
                if (fall) state_nxt = ST_IDLE;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
                else if (hold_done) state_nxt = ST_REPEAT;
`endif
            end
            ST_REPEAT: if (fall) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        press_nxt   = rise | repeat_fire;
        release_nxt = fall;
    end

endmodule

// File: rtl/btn_conditioner.sv
// Button input conditioning: N_BTN independent debounce channels.
// Define BTN_CONDITIONER_AUTOREPEAT_EN to enable auto-repeat presses.
module btn_conditioner
    import calc_pkg::*;
#(
    parameter int unsigned N_BTN           = CALC_N_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned REPEAT_CYCLES   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: sample-window reference model, directed
// scenarios followed by randomized button activity.
module tb_btn_conditioner;

    localparam int NB = 3;
    localparam int D  = 4;
    localparam int H  = 16;
    localparam int R  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release;

    btn_conditioner #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #15 clk = ~clk;

    typedef struct packed {
        logic [NB-1:0] level;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
    } exp_t;

    exp_t sb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   edge_no = 0;

    // Reference model: a level is accepted once the raw line, as seen two edges
    // late through the synchroniser, has held the new value for D samples.
    logic [D+1:0] hist[NB];
    bit           mlevel[NB];
    int           tpress[NB];

    initial begin
        for (int c = 0; c < NB; c++) begin
            hist[c]   = '0;
            mlevel[c] = 1'b0;
            tpress[c] = 0;
        end
    end

    always @(posedge clk) begin : model
        exp_t e;
        e = '0;
        edge_no++;
        for (int c = 0; c < NB; c++) begin
            if (rst) begin
                hist[c]   = '0;
                mlevel[c] = 1'b0;
            end else begin
                hist[c] = {hist[c][D:0], btn_raw[c]};
                if (!mlevel[c] && (&hist[c][D+1:2])) begin
                    mlevel[c]  = 1'b1;
                    e.press[c] = 1'b1;
                    tpress[c]  = edge_no;
                end else if (mlevel[c] && !(|hist[c][D+1:2])) begin
                    mlevel[c] = 1'b0;
                    e.rel[c]  = 1'b1;
                end
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
                else if (mlevel[c] && (edge_no - tpress[c]) >= H &&
                         ((edge_no - tpress[c] - H) % R) == 0) begin
                    e.press[c] = 1'b1;
                end
`endif
            end
            e.level[c] = mlevel[c];
        end
        sb.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({btn_level, btn_press, btn_release} !== e) begin
                errors++;
                $display("FAIL outputs edge %0d: got level=%b press=%b release=%b, expected level=%b press=%b release=%b",
                         edge_no, btn_level, btn_press, btn_release, e.level, e.press, e.rel);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drive one channel and check the edge index (relative to E0) of the resulting pulse.
    task automatic timed_edge(input int ch, input logic val, input string name);
        int  e0;
        bit  seen;
        @(negedge clk);
        #3 btn_raw[ch] = val;
        e0   = edge_no + 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (val ? btn_press[ch] : btn_release[ch]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: no pulse within 20 cycles, required at E%0d", name, D + 1);
        end else if (edge_no - e0 != D + 1) begin
            errors++;
            $display("FAIL %s: pulse at E%0d, required E%0d", name, edge_no - e0, D + 1);
        end
    endtask

    initial begin
        int rem[NB];
        int npress, nexp;

        repeat (3) @(negedge clk);
        #3 rst = 1'b0;
        step(3);

        // Glitches: 20 ns highs, spaced so each is sampled at most once.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            #5  btn_raw[0] = 1'b1;
            #20 btn_raw[0] = 1'b0;
            @(negedge clk);
        end
        step(3);

        // 100 ns pulses: three sampling edges each, too short to accept.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #5   btn_raw[0] = 1'b1;
            #100 btn_raw[0] = 1'b0;
            step(3);
        end

        // Clean press and release on channel 1.
        timed_edge(1, 1'b1, "press_latency");
        step(14);
        timed_edge(1, 1'b0, "release_latency");
        step(4);

        // Bounce on channel 2, then steady high.
        @(negedge clk); #3 btn_raw[2] = 1'b1;
        @(negedge clk); #3 btn_raw[2] = 1'b0;
        @(negedge clk); #3 btn_raw[2] = 1'b1;
        step(12);
        #3 btn_raw[2] = 1'b0;
        step(10);

        // Reset while channel 0 is mid-debounce (after E3), button held through it.
        @(negedge clk); #3 btn_raw[0] = 1'b1;
        step(4);
        #3 rst = 1'b1;
        step(3);
        #3 rst = 1'b0;
        step(12);
        #3 btn_raw[0] = 1'b0;
        step(10);

        // Long hold on channel 0: count press pulses against the repeat rule.
        @(negedge clk); #3 btn_raw[0] = 1'b1;
        npress = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            npress += int'(btn_press[0]);
        end
        #3 btn_raw[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            npress += int'(btn_press[0]);
        end
        nexp = 1;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
        for (int t = D + 1 + H; t < 60 + D + 1; t += R) nexp++;
`endif
        checks++;
        if (npress != nexp) begin
            errors++;
            $display("FAIL hold_press_count: got %0d, required %0d", npress, nexp);
        end
        step(3);

        // Randomized activity with occasional resets.
        for (int c = 0; c < NB; c++) rem[c] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            #3;
            for (int c = 0; c < NB; c++) begin
                if (rem[c] == 0) begin
                    btn_raw[c] = 1'($urandom_range(0, 1));
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 45))
                                                         : int'($urandom_range(1, 8));
                end else begin
                    rem[c]--;
                end
            end
            rst = ($urandom_range(0, 149) == 0);
        end

        @(negedge clk);
        #3 rst = 1'b0;
        btn_raw = '0;
        step(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
